// File: rtl/cordic_pkg.sv
// Shared definitions for the cosine CORDIC accelerator: FSM states, IEEE-754
// single-precision field widths and the default fixed-point format.
package cordic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  // Q1.31 is the format shared by the core and both converters.
  localparam int FRAC_BITS_DEFAULT = 31;
  localparam int WIDTH_DEFAULT     = 32;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised 32-bit magnitude (bit 31 set) down to
// a 23-bit stored mantissa, folding a mantissa carry-out into the exponent.
module fp_round_rne
  import cordic_pkg::*;
(
  input  logic [31:0]          mag,
  input  logic [FP_EXP_W-1:0]  exp_in,
  output logic [FP_MANT_W-1:0] mant,
  output logic [FP_EXP_W-1:0]  exp_out
);

  logic [FP_MANT_W-1:0] mant_raw;
  logic                 lsb;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FP_MANT_W:0]   mant_sum;

  assign mant_raw = mag[30:8];
  assign lsb      = mag[8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = guard & (sticky | lsb);

  // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
  assign mant_sum = {1'b0, mant_raw} + {{FP_MANT_W{1'b0}}, round_up};
  assign mant     = mant_sum[FP_MANT_W-1:0];
  assign exp_out  = exp_in + {{(FP_EXP_W-1){1'b0}}, mant_sum[FP_MANT_W]};

endmodule

// File: rtl/cordic_fix2float.sv
// Signed fixed-point to IEEE-754 single converter, run as a multi-cycle Nios II
// custom instruction: absolute value, one-bit-per-cycle normalise, RNE round.
module cordic_fix2float
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
  parameter int WIDTH     = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  // Exponent of a magnitude whose leading one already sits in bit 31.
  localparam logic [FP_EXP_W-1:0] EXP_BASE = FP_EXP_W'(FP_BIAS + WIDTH - 1 - FRAC_BITS);

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  n_q, n_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;

  logic [FP_EXP_W-1:0]  exp_unr;
  logic [FP_EXP_W-1:0]  rnd_exp;
  logic [FP_MANT_W-1:0] rnd_mant;

  assign exp_unr = EXP_BASE - {{(FP_EXP_W-5){1'b0}}, n_q};

  fp_round_rne u_round (
    .mag     (mag_q),
    .exp_in  (exp_unr),
    .mant    (rnd_mant),
    .exp_out (rnd_exp)
  );

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      n_q      <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      n_q      <= n_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    n_d      = n_q;
    sign_d   = sign_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = dataa[WIDTH-1];
          mag_d   = dataa;
          state_d = ABS;
        end
      end
      ABS: begin
        // 0x80000000 negates to itself, which is exactly the unsigned 2^31.
        mag_d = sign_q ? (~mag_q + 32'd1) : mag_q;
        n_d   = '0;
        if (mag_d == '0) begin
          result_d = '0;
          state_d  = DONE;
        end else if (mag_d[31]) begin
          state_d = ROUND;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        mag_d = {mag_q[30:0], 1'b0};
        n_d   = n_q + 5'd1;
        if (mag_q[30]) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d = {sign_q, rnd_exp, rnd_mant};
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE) && (state_q != DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_cordic_fix2float.sv
// Directed and random checks of cordic_fix2float against an arithmetic
// reference of fixed-point to single-precision conversion.
module tb_cordic_fix2float;

  localparam int FRAC_BITS = 31;

  logic        clk;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  cordic_fix2float #(.FRAC_BITS(FRAC_BITS), .WIDTH(32)) dut (
    .clock  (clk),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic int msb_pos(input longint m);
    int p;
    p = 0;
    for (int i = 0; i < 33; i++) begin
      if (m >= (longint'(1) << i)) p = i;
    end
    return p;
  endfunction

  function automatic longint magnitude(input logic [31:0] v);
    return v[31] ? ((longint'(1) << 32) - longint'(v)) : longint'(v);
  endfunction

  function automatic logic [31:0] ref_float(input logic [31:0] v);
    longint m, q, rem, half;
    int     p, sh, e;
    if (v == 32'd0) return 32'd0;
    m = magnitude(v);
    p = msb_pos(m);
    if (p > 23) begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end else begin
      q = m << (23 - p);
    end
    e = p - FRAC_BITS + 127;
    return {v[31], 8'(e), q[22:0]};
  endfunction

  function automatic int ref_latency(input logic [31:0] v);
    if (v == 32'd0) return 2;
    return 3 + (31 - msb_pos(magnitude(v)));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // driver: one conversion, optional clk_en stall and an extra start while busy
  task automatic convert(input logic [31:0] v, input int stall_at, input bit extra_start,
                         input string tag);
    logic [31:0] exp_res;
    int          exp_lat;
    int          cycles;
    bit          seen;
    exp_lat = ref_latency(v) + ((stall_at > 0) ? 5 : 0);
    exp_q.push_back(ref_float(v));
    @(negedge clk);
    start = 1'b1;
    dataa = v;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        seen = 1'b1;
      end else begin
        start = 1'b0;
        dataa = $urandom;
        if (cycles == 1) check({tag, " busy"}, 32'(busy), 32'd1);
        if (extra_start && cycles == 2) begin
          start = 1'b1;
          dataa = 32'h1234_5678;
        end
        if (stall_at > 0 && cycles == stall_at) clk_en = 1'b0;
        if (stall_at > 0 && cycles == stall_at + 5) clk_en = 1'b1;
      end
    end
    clk_en = 1'b1;
    start  = 1'b0;
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    exp_res = exp_q.pop_front();
    check({tag, " result"}, result, exp_res);
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " result hold"}, result, exp_res);
  endtask

  initial begin
    logic [31:0] v;
    bit          got_done;
    aclr   = 1'b1;
    clk_en = 1'b0;
    start  = 1'b1;
    dataa  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    aclr   = 1'b0;
    start  = 1'b0;
    clk_en = 1'b1;

    // directed values with hand-derived results
    convert(32'h6EC1_BCCD, 0, 1'b0, "cos 0.86529");
    check("cos literal", result, 32'h3F5D_837A);
    convert(32'h8000_0000, 0, 1'b0, "minus one");
    check("minus one literal", result, 32'hBF80_0000);
    convert(32'hC000_0000, 0, 1'b0, "minus half");
    check("minus half literal", result, 32'hBF00_0000);
    convert(32'h0000_0001, 0, 1'b0, "one lsb");
    check("one lsb literal", result, 32'h3000_0000);
    convert(32'h0000_0000, 0, 1'b0, "zero");
    check("zero literal", result, 32'h0000_0000);
    convert(32'h4000_0040, 0, 1'b0, "tie even");
    check("tie even literal", result, 32'h3F00_0000);
    convert(32'h4000_00C0, 0, 1'b0, "tie odd");
    check("tie odd literal", result, 32'h3F00_0002);
    convert(32'h7FFF_FFC0, 0, 1'b0, "mant carry");
    check("mant carry literal", result, 32'h3F80_0000);
    convert(32'hFFFF_FFFF, 0, 1'b0, "minus one lsb");

    // control: clk_en stall inside NORM, start while busy
    convert(32'h0000_0001, 6, 1'b0, "stall norm");
    convert(32'h0001_2345, 0, 1'b1, "busy start");

    // reset during NORM abandons the conversion
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    got_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("abort no done", 32'(got_done), 32'd0);
    convert(32'h2000_0000, 0, 1'b0, "after abort");

    // random values across the whole leading-zero range
    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      convert(v, 0, 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
